// File: rtl/fp_addsub_seq_if.sv
// Operand/result handshake bundle for the sequential FP adder/subtractor.
// The issue side drives the master modport; the adder implements the slave.
interface fp_addsub_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int XLEN = 1 + EXP_W + MAN_W;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            sub;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            overflow;
    logic            underflow;
    logic            invalid;
    logic            inexact;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, invalid, inexact
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, overflow, underflow, invalid, inexact
    );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multicycle IEEE-754 adder/subtractor: one operation in flight, DAZ inputs,
// bit-serial normalisation, round-to-nearest-even and IEEE status flags.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_addsub_seq_if.slave bus
);
    localparam int XLEN = 1 + EXP_W + MAN_W;
    localparam int MW   = MAN_W + 4;   // {hidden, frac, G, R, S}
    localparam int EW   = EXP_W + 2;   // headroom for carries past all-ones

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_ALIGN  = 3'd2;
    localparam logic [2:0] S_ADD    = 3'd3;
    localparam logic [2:0] S_NORM   = 3'd4;
    localparam logic [2:0] S_ROUND  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
    localparam logic [MAN_W-1:0] FRAC_ZERO = {MAN_W{1'b0}};
    localparam logic [EW-1:0]    EXP_MAX  = {2'b00, EXP_ONES};
    localparam logic [EW-1:0]    EXP_ONE  = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;            // b with the effective (sub-adjusted) sign
    logic            sign_q, sign_d;
    logic [EW-1:0]   exp_q, exp_d;
    logic [MW-1:0]   man_q, man_d;
    logic [MW-1:0]   sml_q, sml_d;
    logic            esub_q, esub_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            inv_q, inv_d;
    logic            inx_q, inx_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

    logic             sa_s, sb_s;
    logic [EXP_W-1:0] ea_s, eb_s;
    logic [MAN_W-1:0] fa_s, fb_s;
    logic             a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;

    assign {sa_s, ea_s, fa_s} = a_q;
    assign {sb_s, eb_s, fb_s} = b_q;
    assign a_nan_s  = (ea_s == EXP_ONES) && (fa_s != FRAC_ZERO);
    assign b_nan_s  = (eb_s == EXP_ONES) && (fb_s != FRAC_ZERO);
    assign a_inf_s  = (ea_s == EXP_ONES) && (fa_s == FRAC_ZERO);
    assign b_inf_s  = (eb_s == EXP_ONES) && (fb_s == FRAC_ZERO);
    assign a_zero_s = (ea_s == EXP_ZERO);
    assign b_zero_s = (eb_s == EXP_ZERO);

    // Alignment: larger magnitude becomes the big operand, small one is shifted with sticky
    logic             a_big_s;
    logic [EXP_W-1:0] e_big_s, e_sml_s, diff_s;
    logic [MW-1:0]    m_big_s, m_sml_s, aligned_s;
    logic [2*MW-1:0]  sh_s;

    assign a_big_s   = (ea_s > eb_s) || ((ea_s == eb_s) && (fa_s >= fb_s));
    assign e_big_s   = a_big_s ? ea_s : eb_s;
    assign e_sml_s   = a_big_s ? eb_s : ea_s;
    assign m_big_s   = a_big_s ? {1'b1, fa_s, 3'b000} : {1'b1, fb_s, 3'b000};
    assign m_sml_s   = a_big_s ? {1'b1, fb_s, 3'b000} : {1'b1, fa_s, 3'b000};
    assign diff_s    = e_big_s - e_sml_s;
    assign sh_s      = {m_sml_s, {MW{1'b0}}} >> diff_s;
    assign aligned_s = (diff_s > EXP_W'(MW - 1)) ? {{(MW-1){1'b0}}, 1'b1}
                     : {sh_s[2*MW-1:MW+1], sh_s[MW] | (|sh_s[MW-1:0])};

    logic [MW:0]   sum_s;
    logic [MW-1:0] man_sh_s;
    logic [EW-1:0] exp_dec_s;

    assign sum_s     = esub_q ? ({1'b0, man_q} - {1'b0, sml_q}) : ({1'b0, man_q} + {1'b0, sml_q});
    assign man_sh_s  = {man_q[MW-2:0], 1'b0};
    assign exp_dec_s = exp_q - EXP_ONE;

    // Round-to-nearest-even on G/R/S; a mantissa carry bumps the exponent
    logic             inc_s, rbits_s;
    logic [MAN_W+1:0] rnd_s;
    logic [EW-1:0]    exp_r_s;
    logic [MAN_W-1:0] frac_r_s;

    assign inc_s    = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
    assign rbits_s  = man_q[2] | man_q[1] | man_q[0];
    assign rnd_s    = {1'b0, man_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, inc_s};
    assign exp_r_s  = exp_q + {{(EW-1){1'b0}}, rnd_s[MAN_W+1]};
    assign frac_r_s = rnd_s[MAN_W+1] ? rnd_s[MAN_W:1] : rnd_s[MAN_W-1:0];

    // FSM next-state and per-step datapath updates
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        man_d       = man_q;
        sml_d       = sml_q;
        esub_d      = esub_q;
        res_d       = res_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        inv_d       = inv_q;
        inx_d       = inx_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = {bus.b[XLEN-1] ^ bus.sub, bus.b[XLEN-2:0]};
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    inv_d   = 1'b0;
                    inx_d   = 1'b0;
                    state_d = S_UNPACK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_UNPACK: begin
                state_d = S_DONE;
                if (a_nan_s || b_nan_s) begin
                    res_d = QNAN;
                    inv_d = 1'b1;
                end else if (a_inf_s && b_inf_s) begin
                    if (sa_s != sb_s) begin
                        res_d = QNAN;
                        inv_d = 1'b1;
                    end else begin
                        res_d = a_q;
                    end
                end else if (a_inf_s) begin
                    res_d = a_q;
                end else if (b_inf_s) begin
                    res_d = b_q;
                end else if (a_zero_s && b_zero_s) begin
                    res_d = {sa_s & sb_s, EXP_ZERO, FRAC_ZERO};
                end else if (a_zero_s) begin
                    res_d = b_q;
                end else if (b_zero_s) begin
                    res_d = a_q;
                end else begin
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                sign_d  = a_big_s ? sa_s : sb_s;
                exp_d   = {2'b00, e_big_s};
                man_d   = m_big_s;
                sml_d   = aligned_s;
                esub_d  = sa_s ^ sb_s;
                state_d = S_ADD;
            end
            S_ADD: begin
                if (sum_s == {(MW+1){1'b0}}) begin
                    res_d   = {(XLEN){1'b0}};
                    state_d = S_DONE;
                end else if (sum_s[MW]) begin
                    man_d   = {sum_s[MW:2], sum_s[1] | sum_s[0]};
                    exp_d   = exp_q + EXP_ONE;
                    state_d = S_ROUND;
                end else begin
                    man_d   = sum_s[MW-1:0];
                    state_d = (!sum_s[MW-1] && (exp_q > EXP_ONE)) ? S_NORM : S_ROUND;
                end
            end
            S_NORM: begin
                man_d   = man_sh_s;
                exp_d   = exp_dec_s;
                state_d = (man_sh_s[MW-1] || (exp_dec_s == EXP_ONE)) ? S_ROUND : S_NORM;
            end
            S_ROUND: begin
                state_d = S_DONE;
                if (!man_q[MW-1]) begin
                    res_d = {sign_q, EXP_ZERO, FRAC_ZERO};
                    unf_d = 1'b1;
                    inx_d = 1'b1;
                end else if (exp_r_s >= EXP_MAX) begin
                    res_d = {sign_q, EXP_ONES, FRAC_ZERO};
                    ovf_d = 1'b1;
                    inx_d = 1'b1;
                end else begin
                    res_d = {sign_q, exp_r_s[EXP_W-1:0], frac_r_s};
                    inx_d = rbits_s;
                end
            end
            S_DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers; reset drops any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= {XLEN{1'b0}};
            b_q         <= {XLEN{1'b0}};
            sign_q      <= 1'b0;
            exp_q       <= {EW{1'b0}};
            man_q       <= {MW{1'b0}};
            sml_q       <= {MW{1'b0}};
            esub_q      <= 1'b0;
            res_q       <= {XLEN{1'b0}};
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inv_q       <= 1'b0;
            inx_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            man_q       <= man_d;
            sml_q       <= sml_d;
            esub_q      <= esub_d;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inv_q       <= inv_d;
            inx_q       <= inx_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = res_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.invalid   = inv_q;
    assign bus.inexact   = inx_q;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed single-precision vectors for fp_addsub_seq: results, flags, latency,
// output back-pressure and asynchronous reset during normalisation.
module tb_fp_addsub_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fp_addsub_seq_if #(.EXP_W(8), .MAN_W(23)) bus_if ();

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic [3:0]  flg;   // {overflow, underflow, invalid, inexact}
        int          lat;
    } vec_t;

    vec_t vt [16];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] flags_now();
        return {28'd0, bus_if.overflow, bus_if.underflow, bus_if.invalid, bus_if.inexact};
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        int w = 0;
        while (!bus_if.in_ready && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        bus_if.a        = a;
        bus_if.b        = b;
        bus_if.sub      = sub;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus_if.out_valid && lat < 100);
    endtask

    task automatic drain();
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        vt[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 5};
        vt[1]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 5};
        vt[2]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 5};
        vt[3]  = '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000, 28};
        vt[4]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 4};
        vt[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1001, 5};
        vt[6]  = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0101, 5};
        vt[7]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0010, 2};
        vt[8]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0010, 2};
        vt[9]  = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000, 2};
        vt[10] = '{32'h40400000, 32'h00000000, 1'b0, 32'h40400000, 4'b0000, 2};
        vt[11] = '{32'h00000001, 32'h80000005, 1'b0, 32'h00000000, 4'b0000, 2};
        vt[12] = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000, 2};
        vt[13] = '{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000, 2};
        vt[14] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 5};
        vt[15] = '{32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, 4'b0000, 6};

        bus_if.in_valid  = 1'b0;
        bus_if.a         = 32'd0;
        bus_if.b         = 32'd0;
        bus_if.sub       = 1'b0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check_eq("rst.out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check_eq("rst.result", bus_if.result, 32'd0);
        check_eq("rst.flags", flags_now(), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            start_op(vt[i].a, vt[i].b, vt[i].sub);
            wait_valid(lat);
            check_eq($sformatf("v%0d.result", i), bus_if.result, vt[i].res);
            check_eq($sformatf("v%0d.flags", i), flags_now(), {28'd0, vt[i].flg});
            check_eq($sformatf("v%0d.latency", i), lat, vt[i].lat);
            drain();
            check_eq($sformatf("v%0d.drain_valid", i), {31'd0, bus_if.out_valid}, 32'd0);
            check_eq($sformatf("v%0d.drain_ready", i), {31'd0, bus_if.in_ready}, 32'd1);
        end

        // Back-pressure: result and flags must hold while the consumer stalls
        start_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
        wait_valid(lat);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check_eq($sformatf("hold%0d.result", k), bus_if.result, 32'h7F800000);
            check_eq($sformatf("hold%0d.flags", k), flags_now(), 32'h00000009);
            check_eq($sformatf("hold%0d.valid", k), {31'd0, bus_if.out_valid}, 32'd1);
            check_eq($sformatf("hold%0d.in_ready", k), {31'd0, bus_if.in_ready}, 32'd0);
        end
        drain();

        // Reset while normalising the 23-bit cancellation
        start_op(32'h3F800001, 32'h3F800000, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check_eq("midnorm.pre_valid", {31'd0, bus_if.out_valid}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("midnorm.out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check_eq("midnorm.in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check_eq("midnorm.result", bus_if.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_op(32'h3F800000, 32'h3F800000, 1'b0);
        wait_valid(lat);
        check_eq("post_rst.result", bus_if.result, 32'h40000000);
        check_eq("post_rst.latency", lat, 32'd5);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
